// File: rtl/mmp_iddmm_pkg.sv
// Shared constants and types for the IDDMM host sequencer.
//   MMP_K       word width in bits
//   MMP_N       words per operand
//   MMP_AW      operand RAM address width
//   MMP_TIMEOUT watchdog limit, cycles from task_req to task_end
//   state_e     host sequencer states
package mmp_iddmm_pkg;

    localparam int MMP_K       = 128;
    localparam int MMP_N       = 32;
    localparam int MMP_AW      = $clog2(MMP_N);
    localparam int MMP_TIMEOUT = 4095;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_RUN,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/mmp_res_fifo.sv
// Result FIFO between the IDDMM core and the host: first-word fall-through,
// so pop_data shows the head entry whenever empty is low.
//   clk, rst        clock, asynchronous active-high reset
//   flush           discard all entries (wins over push/pop)
//   push, push_data write one entry; dropped if full and no pop this cycle
//   pop, pop_data   consume the head entry; ignored when empty
//   count           number of stored entries
//   full, empty     status flags
module mmp_res_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; consumers gate pop_data with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mmp_iddmm_host_if.sv
// Host-side sequencer for the IDDMM core. Loads one operand set from the
// host into the core's operand RAMs, pulses task_req, captures the N result
// words the core emits unthrottled and streams them back to the host.
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         host operand beat handshake
//   in_x/in_y/in_m            operand words, low word first
//   in_m1                     m1, sampled on the first beat of a job
//   out_valid/out_ready       host result handshake
//   out_data/out_last         result word, last marks word N-1
//   busy                      sequencer not idle
//   err_timeout, err_count    sticky job errors, cleared by next first beat
//   wr_ena/wr_addr/wr_*       operand RAM write port of the core
//   task_req                  one-cycle start pulse to the core
//   task_end/task_grant/task_res  core completion and result stream
module mmp_iddmm_host_if
    import mmp_iddmm_pkg::*;
#(
    parameter int K       = MMP_K,
    parameter int N       = MMP_N,
    parameter int TIMEOUT = MMP_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K-1:0]         in_x,
    input  logic [K-1:0]         in_y,
    input  logic [K-1:0]         in_m,
    input  logic [K-1:0]         in_m1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K-1:0]         out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_count,
    output logic                 wr_ena,
    output logic [$clog2(N)-1:0] wr_addr,
    output logic [K-1:0]         wr_x,
    output logic [K-1:0]         wr_y,
    output logic [K-1:0]         wr_m,
    output logic [K-1:0]         wr_m1,
    output logic                 task_req,
    input  logic                 task_end,
    input  logic                 task_grant,
    input  logic [K-1:0]         task_res
);

    localparam int AW   = $clog2(N);
    localparam int CW   = $clog2(N + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [AW-1:0] beat_cnt_q, beat_cnt_d;   // address of the next LOAD beat
    logic          wr_ena_q, wr_ena_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [K-1:0]  wr_x_q, wr_x_d;
    logic [K-1:0]  wr_y_q, wr_y_d;
    logic [K-1:0]  wr_m_q, wr_m_d;
    logic [K-1:0]  wr_m1_q, wr_m1_d;
    logic          task_req_q, task_req_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;     // grants pushed this job
    logic [AW-1:0] pop_cnt_q, pop_cnt_d;     // index of the next result popped
    logic          err_timeout_q, err_timeout_d;
    logic          err_count_q, err_count_d;

    logic          accept;
    logic          fifo_push, fifo_pop, fifo_flush;
    logic [K-1:0]  fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    mmp_res_fifo #(
        .W     (K),
        .DEPTH (N)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (task_res),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign accept      = in_valid && in_ready;

    // Popping starts while the core is still producing, so drain overlaps capture.
    assign out_valid   = !fifo_empty && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign fifo_pop    = out_valid && out_ready;
    assign out_data    = out_valid ? fifo_data : '0;
    assign out_last    = out_valid && (pop_cnt_q == AW'(N - 1));

    assign wr_ena      = wr_ena_q;
    assign wr_addr     = wr_addr_q;
    assign wr_x        = wr_x_q;
    assign wr_y        = wr_y_q;
    assign wr_m        = wr_m_q;
    assign wr_m1       = wr_m1_q;
    assign task_req    = task_req_q;
    assign err_timeout = err_timeout_q;
    assign err_count   = err_count_q;

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        wr_ena_d      = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_x_d        = wr_x_q;
        wr_y_d        = wr_y_q;
        wr_m_d        = wr_m_q;
        wr_m1_d       = wr_m1_q;
        task_req_d    = 1'b0;
        wd_d          = wd_q;
        res_cnt_d     = res_cnt_q;
        pop_cnt_d     = pop_cnt_q + AW'(fifo_pop);
        err_timeout_d = err_timeout_q;
        err_count_d   = err_count_q;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_ena_d      = 1'b1;
                    wr_addr_d     = '0;
                    wr_x_d        = in_x;
                    wr_y_d        = in_y;
                    wr_m_d        = in_m;
                    wr_m1_d       = in_m1;
                    err_timeout_d = 1'b0;
                    err_count_d   = 1'b0;
                    beat_cnt_d    = AW'(1);
                    res_cnt_d     = '0;
                    pop_cnt_d     = '0;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_ena_d   = 1'b1;
                    wr_addr_d  = beat_cnt_q;
                    wr_x_d     = in_x;
                    wr_y_d     = in_y;
                    wr_m_d     = in_m;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == AW'(N - 1)) state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The last RAM write is on the bus this cycle; start the
                // core on the next one. The REQ cycle counts toward the watchdog.
                task_req_d = 1'b1;
                wd_d       = WD_W'(1);
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                fifo_push = task_grant;
                if (task_grant) res_cnt_d = res_cnt_q + 1'b1;
                if (task_end) begin
                    if ((res_cnt_q + CW'(task_grant)) != CW'(N)) err_count_d = 1'b1;
                    state_d = ST_DRAIN;
                end else if (wd_q >= WD_W'(TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                    fifo_push     = 1'b0;
                    fifo_flush    = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (task_end) err_count_d = 1'b1;
                if (fifo_count == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Overflow cannot happen with a well-behaved core; flag it if it does.
        if (fifo_push && fifo_full && !fifo_pop) err_count_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            wr_ena_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_x_q        <= '0;
            wr_y_q        <= '0;
            wr_m_q        <= '0;
            wr_m1_q       <= '0;
            task_req_q    <= 1'b0;
            wd_q          <= '0;
            res_cnt_q     <= '0;
            pop_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
            err_count_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            wr_ena_q      <= wr_ena_d;
            wr_addr_q     <= wr_addr_d;
            wr_x_q        <= wr_x_d;
            wr_y_q        <= wr_y_d;
            wr_m_q        <= wr_m_d;
            wr_m1_q       <= wr_m1_d;
            task_req_q    <= task_req_d;
            wd_q          <= wd_d;
            res_cnt_q     <= res_cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
        end
    end

endmodule
